// File: rtl/cmp_result_monitor.sv
// cmp_result_monitor: outcome counters and match-lock FSM behind the comparator.
// Optional macro CMP_MON_ONEHOT_CHECK_EN enables one-hot flag checking.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clear                 sync clear of counters, FSM and error flag
//   in_valid              flags carry a sample this cycle
//   a_less_b/a_equal_b/
//   a_greater_b           comparator result flags
//   less_cnt/equal_cnt/
//   greater_cnt           saturating outcome counters
//   locked                high in LOCKED and SLIP
//   lock_event            pulse on SEARCH -> LOCKED
//   unlock_event          pulse on return to SEARCH
//   flag_err              sticky illegal-flag indicator (0 without macro)
module cmp_result_monitor #(
  parameter int CNT_W      = 8,
  parameter int LOCK_RUN   = 4,
  parameter int UNLOCK_RUN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             a_less_b,
  input  logic             a_equal_b,
  input  logic             a_greater_b,
  output logic [CNT_W-1:0] less_cnt,
  output logic [CNT_W-1:0] equal_cnt,
  output logic [CNT_W-1:0] greater_cnt,
  output logic             locked,
  output logic             lock_event,
  output logic             unlock_event,
  output logic             flag_err
);

  typedef enum logic [1:0] {
    SEARCH,
    LOCKED,
    SLIP
  } state_t;

  typedef enum logic [2:0] {
    K_NONE,
    K_EQ,
    K_LT,
    K_GT,
    K_ERR
  } kind_t;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_RUN);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_RUN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state_q;
  state_t     state_d;
  logic [3:0] run_q;
  logic [3:0] run_d;
  logic [3:0] run_inc;
  logic       lock_ev_d;
  logic       unlock_ev_d;
  kind_t      kind;
  logic       miss;

  // Sample classification; equal wins over less, less over greater.
  always_comb begin
    kind = K_NONE;
    if (in_valid) begin
      priority case (1'b1)
        a_equal_b:   kind = K_EQ;
        a_less_b:    kind = K_LT;
        a_greater_b: kind = K_GT;
        default:     kind = K_NONE;
      endcase
`ifdef CMP_MON_ONEHOT_CHECK_EN
      if (!$onehot({a_less_b, a_equal_b, a_greater_b}))
        kind = K_ERR;
`endif
    end
  end

  // ERR breaks a lock exactly like a real mismatch.
  assign miss = (kind == K_LT) ||
                (kind == K_GT) ||
                (kind == K_ERR);

  assign run_inc = run_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    lock_ev_d   = 1'b0;
    unlock_ev_d = 1'b0;
    if (kind != K_NONE) begin
      unique case (state_q)
        SEARCH: begin
          if (kind == K_EQ) begin
            if (run_inc == LOCK_N) begin
              state_d   = LOCKED;
              run_d     = 4'd0;
              lock_ev_d = 1'b1;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = 4'd0;
          end
        end
        LOCKED: begin
          if (miss) begin
            if (UNLOCK_N == 4'd1) begin
              state_d     = SEARCH;
              run_d       = 4'd0;
              unlock_ev_d = 1'b1;
            end else begin
              state_d = SLIP;
              run_d   = 4'd1;
            end
          end
        end
        SLIP: begin
          if (kind == K_EQ) begin
            state_d = LOCKED;
            run_d   = 4'd0;
          end else if (run_inc == UNLOCK_N) begin
            state_d     = SEARCH;
            run_d       = 4'd0;
            unlock_ev_d = 1'b1;
          end else begin
            run_d = run_inc;
          end
        end
        default: begin
          state_d = SEARCH;
          run_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      run_q        <= 4'd0;
      lock_event   <= 1'b0;
      unlock_event <= 1'b0;
    end else if (clear) begin
      state_q      <= SEARCH;
      run_q        <= 4'd0;
      lock_event   <= 1'b0;
      unlock_event <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      lock_event   <= lock_ev_d;
      unlock_event <= unlock_ev_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      less_cnt    <= '0;
      equal_cnt   <= '0;
      greater_cnt <= '0;
    end else if (clear) begin
      less_cnt    <= '0;
      equal_cnt   <= '0;
      greater_cnt <= '0;
    end else begin
      if (kind == K_LT && less_cnt != CNT_MAX)
        less_cnt <= less_cnt + CNT_ONE;
      if (kind == K_EQ && equal_cnt != CNT_MAX)
        equal_cnt <= equal_cnt + CNT_ONE;
      if (kind == K_GT && greater_cnt != CNT_MAX)
        greater_cnt <= greater_cnt + CNT_ONE;
    end
  end

  assign locked = (state_q != SEARCH);

`ifdef CMP_MON_ONEHOT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flag_err <= 1'b0;
    else if (clear)
      flag_err <= 1'b0;
    else if (kind == K_ERR)
      flag_err <= 1'b1;
  end
`else
  assign flag_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_result_monitor.sv
// tb_cmp_result_monitor: scoreboard bench for cmp_result_monitor.
// Reference model pushes expected outputs; DUT outputs popped each cycle.
module tb_cmp_result_monitor;

  localparam int LR = 4;
  localparam int UR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       a_less_b = 1'b0;
  logic       a_equal_b = 1'b0;
  logic       a_greater_b = 1'b0;
  logic [7:0] less_cnt;
  logic [7:0] equal_cnt;
  logic [7:0] greater_cnt;
  logic       locked;
  logic       lock_event;
  logic       unlock_event;
  logic       flag_err;

  cmp_result_monitor #(
    .CNT_W(8),
    .LOCK_RUN(LR),
    .UNLOCK_RUN(UR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .in_valid(in_valid),
    .a_less_b(a_less_b),
    .a_equal_b(a_equal_b),
    .a_greater_b(a_greater_b),
    .less_cnt(less_cnt),
    .equal_cnt(equal_cnt),
    .greater_cnt(greater_cnt),
    .locked(locked),
    .lock_event(lock_event),
    .unlock_event(unlock_event),
    .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  string phase = "init";

  logic [27:0] exp_q[$];

  int m_state, m_run;
  int m_lt, m_eq, m_gt;
  bit m_lev, m_uev, m_err;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] dut_obs();
    return {less_cnt, equal_cnt, greater_cnt,
            locked, lock_event, unlock_event, flag_err};
  endfunction

  function automatic logic [27:0] model_obs();
    logic [27:0] o;
    o = {m_lt[7:0], m_eq[7:0], m_gt[7:0],
         (m_state != 0), m_lev, m_uev, m_err};
    return o;
  endfunction

  task automatic model_reset();
    m_state = 0; m_run = 0;
    m_lt = 0; m_eq = 0; m_gt = 0;
    m_lev = 0; m_uev = 0; m_err = 0;
  endtask

  // f = {less, equal, greater}
  task automatic model_step(input bit c, input bit v,
                            input logic [2:0] f);
    int k;
    m_lev = 0;
    m_uev = 0;
    if (c) begin
      model_reset();
      return;
    end
    if (!v) return;
    if (f[1]) k = 1;
    else if (f[2]) k = 2;
    else if (f[0]) k = 3;
    else k = 0;
`ifdef CMP_MON_ONEHOT_CHECK_EN
    if ($countones(f) != 1) k = 4;
`endif
    if (k == 1 && m_eq < 255) m_eq++;
    if (k == 2 && m_lt < 255) m_lt++;
    if (k == 3 && m_gt < 255) m_gt++;
    if (k == 4) m_err = 1;
    if (k == 0) return;
    case (m_state)
      0: begin
        if (k == 1) begin
          m_run++;
          if (m_run == LR) begin
            m_state = 1; m_run = 0; m_lev = 1;
          end
        end else m_run = 0;
      end
      1: begin
        if (k != 1) begin
          if (UR == 1) begin
            m_state = 0; m_run = 0; m_uev = 1;
          end else begin
            m_state = 2; m_run = 1;
          end
        end
      end
      default: begin
        if (k == 1) begin
          m_state = 1; m_run = 0;
        end else begin
          m_run++;
          if (m_run == UR) begin
            m_state = 0; m_run = 0; m_uev = 1;
          end
        end
      end
    endcase
  endtask

  // Move to the falling edge and score the previous cycle's result.
  task automatic sync();
    logic [27:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(phase, 32'(dut_obs()), 32'(e));
    end
  endtask

  task automatic drive(input bit c, input bit v,
                       input logic [2:0] f);
    clear = c;
    in_valid = v;
    {a_less_b, a_equal_b, a_greater_b} = f;
    if (!rst_n) model_reset();
    else model_step(c, v, f);
    exp_q.push_back(model_obs());
  endtask

  task automatic cyc(input bit c, input bit v,
                     input logic [2:0] f);
    sync();
    drive(c, v, f);
  endtask

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;
  localparam logic [2:0] NO = 3'b000;

  initial begin
    model_reset();

    phase = "reset";
    repeat (3) begin
      sync();
      rst_n = 1'b0;
      drive(0, 1, 3'($urandom));
    end
    sync();
    rst_n = 1'b1;
    drive(0, 1, EQ);
    cyc(0, 1, EQ);
    cyc(0, 1, EQ);
    sync();
    check("rst_eq_cnt", 32'(equal_cnt), 32'd3);
    check("rst_locked", 32'(locked), 32'd0);
    drive(1, 0, NO);

    phase = "lock";
    cyc(0, 1, EQ);
    cyc(0, 1, EQ);
    cyc(0, 0, EQ);
    cyc(0, 0, NO);
    cyc(0, 1, EQ);
    cyc(0, 1, EQ);
    sync();
    check("lock_ev", 32'(lock_event), 32'd1);
    check("lock_lk", 32'(locked), 32'd1);
    drive(0, 1, LT);
    cyc(0, 1, EQ);
    sync();
    check("slip_lk", 32'(locked), 32'd1);
    check("slip_uev", 32'(unlock_event), 32'd0);
    drive(1, 0, NO);

    phase = "unlock";
    repeat (4) cyc(0, 1, EQ);
    cyc(0, 1, GT);
    cyc(0, 1, LT);
    sync();
    check("unl_uev", 32'(unlock_event), 32'd1);
    check("unl_lk", 32'(locked), 32'd0);
    check("unl_lt", 32'(less_cnt), 32'd1);
    check("unl_gt", 32'(greater_cnt), 32'd1);
    drive(1, 0, NO);

    phase = "sat";
    repeat (300) cyc(0, 1, LT);
    sync();
    check("sat_lt", 32'(less_cnt), 32'd255);
    check("sat_eq", 32'(equal_cnt), 32'd0);
    check("sat_lk", 32'(locked), 32'd0);
    drive(1, 0, NO);

    phase = "async";
    cyc(0, 1, EQ);
    cyc(0, 1, EQ);
    sync();
    drive(0, 0, NO);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 32'(dut_obs()), 32'd0);
    void'(exp_q.pop_back());
    model_reset();
    exp_q.push_back(model_obs());
    sync();
    rst_n = 1'b1;
    drive(0, 1, EQ);
    cyc(0, 1, EQ);
    sync();
    check("async_lk", 32'(locked), 32'd0);
    drive(1, 0, NO);

    phase = "clr_coll";
    repeat (4) cyc(0, 1, EQ);
    cyc(0, 1, GT);
    cyc(0, 1, EQ);
    cyc(1, 1, EQ);
    sync();
    check("coll_obs", 32'(dut_obs()), 32'd0);
    drive(0, 0, NO);

    phase = "onehot";
    cyc(0, 1, 3'b011);
    cyc(0, 1, 3'b000);
    cyc(0, 0, NO);
    sync();
`ifdef CMP_MON_ONEHOT_CHECK_EN
    check("oh_err", 32'(flag_err), 32'd1);
    check("oh_eq", 32'(equal_cnt), 32'd0);
`else
    check("oh_err", 32'(flag_err), 32'd0);
    check("oh_eq", 32'(equal_cnt), 32'd1);
`endif
    drive(0, 1, LT);

    phase = "random";
    repeat (400) begin
      cyc(($urandom_range(0, 31) == 0),
          ($urandom_range(0, 3) != 0),
          3'($urandom));
    end
    cyc(0, 0, NO);
    sync();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
